reordenar_vetores_pipe: RTL and testbench
=========================================

REORDENAR_VETORES_PIPE -- requirements
Module: reordenar_vetores_pipe

Interface
REQ-001 Parameter DATA_W, default 32, entrada/saida width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter CNT_W, default 32, width of the beat counter.
REQ-003 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 entrada  input  DATA_W  input word.
REQ-006 modo  input  2  permutation mode, sampled together with entrada.
REQ-007 entrada_valid  input  1  entrada/modo valid.
REQ-008 entrada_ready  output  1  block can accept a beat; registered.
REQ-009 saida  output  DATA_W  permuted word.
REQ-010 saida_valid  output  1  saida valid.
REQ-011 saida_ready  input  1  downstream accepts saida.
REQ-012 contador  output  CNT_W  output beats transferred; present only with REORDENAR_CONTADOR_EN.

Function
REQ-013 Input beat SHALL be accepted when entrada_valid=1 and entrada_ready=1 on a rising edge; output beat SHALL be transferred when saida_valid=1 and saida_ready=1.
REQ-014 Permutation, 4-bit nibble n0 = LSB, byte k = bits 8k+7..8k: modo 00 pass-through; 01 byte order reversed; 10 two nibbles swapped inside every byte; 11 all nibbles reversed.
REQ-015 The mode SHALL be applied per beat using modo captured at acceptance; a modo change between beats SHALL NOT affect beats already accepted.
REQ-016 Latency SHALL be exactly one cycle: a beat accepted at edge N into an empty block appears on saida with saida_valid=1 after edge N.
REQ-017 Storage SHALL be an output register plus one skid register; FSM states VAZIO, CHEIO, SKID.
REQ-018 VAZIO: saida_valid=0, entrada_ready=1; accept -> CHEIO.
REQ-019 CHEIO: saida_valid=1, entrada_ready=1; accept+transfer -> CHEIO with new word; accept only -> SKID (word into skid); transfer only -> VAZIO; neither -> hold.
REQ-020 SKID: saida_valid=1, entrada_ready=0; transfer -> CHEIO with skid word moved to saida; else hold.
REQ-021 While saida_valid=1 and saida_ready=0, saida SHALL remain stable.
REQ-022 Beats SHALL leave in acceptance order, none lost or duplicated; full throughput (one beat/cycle) SHALL be sustained with saida_ready held 1.
REQ-023 contador SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-024 With rst_n=0 at an edge: state VAZIO, saida_valid=0, entrada_ready=1, saida=0, skid contents cleared, contador=0.
REQ-025 Reset mid-operation (any state) SHALL discard all held beats; no beat SHALL be accepted or transferred on a reset edge.

Configuration
REQ-026 Macro REORDENAR_CONTADOR_EN: defined -> contador port and counter logic present per REQ-023; undefined -> port and logic absent, all other behaviour identical.

Structure
REQ-027 Package reordenar_pkg SHALL hold the modo constants (MODO_PASSA, MODO_BYTE_REV, MODO_NIB_SWAP, MODO_NIB_REV) and the FSM state encoding.
REQ-028 Combinational permutation SHALL live in sub-module reordenar_rede (parameter DATA_W; ports word in, modo, word out), instantiated once at the input side.

Verification (DATA_W=32)
REQ-029 modo=01, entrada=0x12345678, saida_ready=1 -> saida=0x78563412, saida_valid=1 one cycle later.
REQ-030 modo=10 then 11 on consecutive beats, entrada=0x12345678 both -> saida 0x21436587 then 0x87654321 on consecutive cycles.
REQ-031 saida_ready=0, send A=0x11111111, B=0x22222222 -> entrada_ready=0 after B, C held by source; saida_ready=1 -> A, B, C in order, saida stable while stalled.
REQ-032 State SKID, rst_n=0 one cycle -> next cycle saida_valid=0, entrada_ready=1, saida=0, contador=0; held beats never appear.
REQ-033 Contador build, CNT_W=3, 9 transfers at saida_ready=1 -> contador=1 (wrap).
REQ-034 Random valid/ready over 1000 beats, all modes -> output equals reference permutation of input stream, in order.

Source files
------------

// File: rtl/reordenar_pkg.sv
// Shared constants for the vector reorder pipeline: the per-beat permutation
// modes and the encoding of the output-buffer state machine.
package reordenar_pkg;

    // Permutation selected by modo
    localparam logic [1:0] MODO_PASSA    = 2'b00;
    localparam logic [1:0] MODO_BYTE_REV = 2'b01;
    localparam logic [1:0] MODO_NIB_SWAP = 2'b10;
    localparam logic [1:0] MODO_NIB_REV  = 2'b11;

    // Occupancy of the output register plus skid register
    typedef enum logic [1:0] {
        VAZIO = 2'b00,
        CHEIO = 2'b01,
        SKID  = 2'b10
    } estado_t;

endpackage

// File: rtl/reordenar_rede.sv
// Purely combinational permutation network. Nibble 0 is the LSB nibble and
// byte k occupies bits 8k+7..8k. Reversing all nibbles is the composition of
// a byte reversal and a nibble swap inside every byte.
module reordenar_rede
    import reordenar_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] palavra_in,
    input  logic [1:0]        modo,
    output logic [DATA_W-1:0] palavra_out
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] byte_rev;
    logic [DATA_W-1:0] nib_swap;
    logic [DATA_W-1:0] nib_rev;

    // Build every candidate permutation, then select one by modo
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byte_rev    = '0;
        nib_swap    = '0;
        nib_rev     = '0;
        palavra_out = palavra_in;
        for (int k = 0; k < NB; k++) begin
            byte_rev[8*k +: 8] = palavra_in[8*(NB-1-k) +: 8];
            nib_swap[8*k +: 8] = {palavra_in[8*k +: 4], palavra_in[8*k+4 +: 4]};
        end
        for (int k = 0; k < NB; k++) begin
            nib_rev[8*k +: 8] = {byte_rev[8*k +: 4], byte_rev[8*k+4 +: 4]};
        end
        case (modo)
            MODO_BYTE_REV: palavra_out = byte_rev;
            MODO_NIB_SWAP: palavra_out = nib_swap;
            MODO_NIB_REV:  palavra_out = nib_rev;
            default:       palavra_out = palavra_in;
        endcase
    end

endmodule

// File: rtl/reordenar_vetores_pipe.sv
// Vector reorder pipeline: permutes each accepted word according to the modo
// captured with it and presents it one cycle later through a valid/ready
// output register backed by a single skid register, so full throughput is
// kept while entrada_ready stays a registered signal.
// Optional feature macro: REORDENAR_CONTADOR_EN adds the contador port, a
// wrapping count of output transfers.
module reordenar_vetores_pipe
    import reordenar_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] entrada,
    input  logic [1:0]        modo,
    input  logic              entrada_valid,
    output logic              entrada_ready,
    output logic [DATA_W-1:0] saida,
    output logic              saida_valid,
    input  logic              saida_ready
`ifdef REORDENAR_CONTADOR_EN
    ,
    output logic [CNT_W-1:0]  contador
`endif
);

    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_chk_data_w
        $error("DATA_W must be a multiple of 8 and at least 8");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $error("CNT_W must be at least 1");
    end

    estado_t           estado;
    estado_t           estado_prox;
    logic [DATA_W-1:0] perm;
    logic [DATA_W-1:0] saida_q;
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;
    logic              aceita;
    logic              transfere;
    logic              ld_saida_in;
    logic              ld_saida_skid;
    logic              ld_skid;

    // Permutation sits on the input side so the stored words are already final
    reordenar_rede #(
        .DATA_W (DATA_W)
    ) u_rede (
        .palavra_in  (entrada),
        .modo        (modo),
        .palavra_out (perm)
    );

    assign aceita        = entrada_valid && ready_q;
    assign transfere     = saida_valid && saida_ready;
    assign saida_valid   = (estado != VAZIO);
    assign entrada_ready = ready_q;
    assign saida         = saida_q;

    // Next state and register load strobes from the current occupancy and handshakes
    always_comb begin
        estado_prox   = estado;
        ld_saida_in   = 1'b0;
        ld_saida_skid = 1'b0;
        ld_skid       = 1'b0;
        case (estado)
            VAZIO: begin
                if (aceita) begin
                    ld_saida_in = 1'b1;
                    estado_prox = CHEIO;
                end
            end
            CHEIO: begin
                case ({aceita, transfere})
                    2'b11: ld_saida_in = 1'b1;
                    2'b10: begin
                        ld_skid     = 1'b1;
                        estado_prox = SKID;
                    end
                    2'b01: estado_prox = VAZIO;
                    default: estado_prox = CHEIO;
                endcase
            end
            SKID: begin
                if (transfere) begin
                    ld_saida_skid = 1'b1;
                    estado_prox   = CHEIO;
                end
            end
            default: estado_prox = VAZIO;
        endcase
    end

    // State register; ready is registered from the next state so it never depends on saida_ready combinationally
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            estado  <= VAZIO;
            ready_q <= 1'b1;
        end else begin
            estado  <= estado_prox;
            ready_q <= (estado_prox != SKID);
        end
    end

    // Data registers: output word and the single skid word
    always_ff @(posedge clk) begin
        // NOTE: the data registers are cleared on reset because saida must read 0 and held beats must vanish.
        if (!rst_n) begin
            saida_q <= '0;
            skid_q  <= '0;
        end else begin
            if (ld_saida_in) begin
                saida_q <= perm;
            end else if (ld_saida_skid) begin
                saida_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= perm;
            end
        end
    end

`ifdef REORDENAR_CONTADOR_EN
    logic [CNT_W-1:0] contador_q;

    // Count output transfers, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            contador_q <= '0;
        end else if (transfere) begin
            contador_q <= contador_q + CNT_W'(1);
        end
    end

    assign contador = contador_q;
`endif

endmodule

// File: tb/tb_reordenar_vetores_pipe.sv
// Self-checking bench for reordenar_vetores_pipe (DATA_W=32, CNT_W=3).
// Build with REORDENAR_CONTADOR_EN defined to also exercise contador.
module tb_reordenar_vetores_pipe;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] entrada;
    logic [1:0]        modo;
    logic              entrada_valid;
    logic              entrada_ready;
    logic [DATA_W-1:0] saida;
    logic              saida_valid;
    logic              saida_ready;
`ifdef REORDENAR_CONTADOR_EN
    logic [CNT_W-1:0]  contador;
`endif

    always #5 clk = ~clk;

    reordenar_vetores_pipe #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entrada       (entrada),
        .modo          (modo),
        .entrada_valid (entrada_valid),
        .entrada_ready (entrada_ready),
        .saida         (saida),
        .saida_valid   (saida_valid),
        .saida_ready   (saida_ready)
`ifdef REORDENAR_CONTADOR_EN
        ,
        .contador      (contador)
`endif
    );

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] sb_q[$];
    logic              stall_prev;
    logic [DATA_W-1:0] stall_word;
    int                exp_cnt;

    // Reference permutation: output nibble i takes input nibble src(i)
    function automatic logic [31:0] ref_perm(input logic [31:0] w, input logic [1:0] m);
        logic [31:0] r;
        int          src;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'b00:   src = i;
                2'b01:   src = (3 - i / 2) * 2 + (i % 2);
                2'b10:   src = i ^ 1;
                default: src = 7 - i;
            endcase
            r[4*i +: 4] = w[4*src +: 4];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then advance past the rising edge
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            sb_q.delete();
            stall_prev = 1'b0;
            exp_cnt    = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(saida_valid), 64'd1);
                chk("stall_stable", 64'(saida), 64'(stall_word));
            end
            if (saida_valid && saida_ready) begin
                n_checks++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_out: observed=%0h expected=no beat", saida);
                end
                if (sb_q.size() != 0) begin
                    chk("scoreboard", 64'(saida), 64'(sb_q.pop_front()));
                end
                exp_cnt++;
            end
            stall_prev = saida_valid && !saida_ready;
            stall_word = saida;
            if (entrada_valid && entrada_ready) begin
                sb_q.push_back(ref_perm(entrada, modo));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded)
    task automatic put(input logic [31:0] d, input logic [1:0] m);
        logic ok;
        int   t;
        entrada       = d;
        modo          = m;
        entrada_valid = 1'b1;
        ok            = 1'b0;
        t             = 0;
        while (!ok && t < 50) begin
            ok = entrada_ready;
            tick();
            t++;
        end
        chk("put_accept_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        int accepted;
        int cycles;

        rst_n         = 1'b0;
        entrada       = '0;
        modo          = 2'b00;
        entrada_valid = 1'b0;
        saida_ready   = 1'b0;
        stall_prev    = 1'b0;
        stall_word    = '0;
        exp_cnt       = 0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", 64'(saida_valid), 64'd0);
        chk("rst_ready", 64'(entrada_ready), 64'd1);
        chk("rst_saida", 64'(saida), 64'd0);
`ifdef REORDENAR_CONTADOR_EN
        chk("rst_contador", 64'(contador), 64'd0);
`endif

        // Byte reversal, one-cycle latency
        saida_ready   = 1'b1;
        entrada       = 32'h12345678;
        modo          = 2'b01;
        entrada_valid = 1'b1;
        tick();
        entrada_valid = 1'b0;
        chk("byte_rev_data", 64'(saida), 64'h78563412);
        chk("byte_rev_valid", 64'(saida_valid), 64'd1);
        tick();
        chk("byte_rev_drained", 64'(saida_valid), 64'd0);

        // Mode changes on consecutive beats
        entrada       = 32'h12345678;
        modo          = 2'b10;
        entrada_valid = 1'b1;
        tick();
        chk("nib_swap_data", 64'(saida), 64'h21436587);
        modo = 2'b11;
        tick();
        chk("nib_rev_data", 64'(saida), 64'h87654321);
        entrada_valid = 1'b0;
        modo          = 2'b00;
        tick();
        chk("mode_seq_drained", 64'(saida_valid), 64'd0);

        // Backpressure fills the skid register; order kept and output stable
        saida_ready = 1'b0;
        put(32'h11111111, 2'b00);
        put(32'h22222222, 2'b00);
        chk("skid_ready_low", 64'(entrada_ready), 64'd0);
        entrada       = 32'h33333333;
        entrada_valid = 1'b1;
        repeat (3) tick();
        chk("stall_head", 64'(saida), 64'h11111111);
        chk("stall_ready_low", 64'(entrada_ready), 64'd0);
        saida_ready = 1'b1;
        tick();
        chk("order_b", 64'(saida), 64'h22222222);
        tick();
        entrada_valid = 1'b0;
        chk("order_c", 64'(saida), 64'h33333333);
        tick();
        chk("order_drained", 64'(saida_valid), 64'd0);

        // Reset while in SKID discards held beats
        saida_ready = 1'b0;
        put(32'hDEADBEEF, 2'b01);
        put(32'hCAFEF00D, 2'b11);
        entrada_valid = 1'b0;
        chk("pre_reset_skid", 64'(entrada_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 64'(saida_valid), 64'd0);
        chk("midrst_ready", 64'(entrada_ready), 64'd1);
        chk("midrst_saida", 64'(saida), 64'd0);
`ifdef REORDENAR_CONTADOR_EN
        chk("midrst_contador", 64'(contador), 64'd0);
`endif
        saida_ready = 1'b1;
        repeat (3) tick();
        chk("midrst_no_ghost", 64'(saida_valid), 64'd0);

        // Nine back-to-back transfers wrap a 3-bit counter to 1
        for (int i = 0; i < 9; i++) begin
            put(32'h01000000 * i + 32'h0000A5A5, 2'(i));
        end
        entrada_valid = 1'b0;
        tick();
        chk("nine_drained", 64'(saida_valid), 64'd0);
`ifdef REORDENAR_CONTADOR_EN
        chk("contador_wrap", 64'(contador), 64'd1);
`endif

        // Random valid/ready over 1000 accepted beats
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 20000) begin
            entrada       = $urandom;
            modo          = 2'($urandom_range(0, 3));
            entrada_valid = ($urandom_range(0, 2) != 0);
            saida_ready   = ($urandom_range(0, 3) != 0);
            if (entrada_valid && entrada_ready) begin
                accepted++;
            end
            tick();
            cycles++;
        end
        chk("rand_beats", 64'(accepted), 64'd1000);
        entrada_valid = 1'b0;
        saida_ready   = 1'b1;
        repeat (5) tick();
        chk("rand_drain_empty", 64'(sb_q.size()), 64'd0);
        chk("rand_drain_valid", 64'(saida_valid), 64'd0);
`ifdef REORDENAR_CONTADOR_EN
        chk("rand_contador", 64'(contador), 64'(exp_cnt % 8));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
